// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: start/operand/result bundle between the opcode decoder and the sequencer.
interface matmul_sequencer_if #(
    parameter int DIM = 5,
    parameter int EW  = 8
);
    localparam int MW = DIM * DIM * EW;
    logic          start;
    logic [2:0]    size_in;
    logic [MW-1:0] matrix_a;
    logic [MW-1:0] matrix_b;
    logic          busy;
    logic          done;
    logic [MW-1:0] result_out;
    logic          overflow_flag;
    modport master (
        output start, size_in, matrix_a, matrix_b,
        input  busy, done, result_out, overflow_flag
    );
    modport slave (
        input  start, size_in, matrix_a, matrix_b,
        output busy, done, result_out, overflow_flag
    );
endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: one shared signed multiplier/accumulator stepped over i/j/k to form an n x n product.
module matmul_sequencer #(
    parameter int DIM   = 5,
    parameter int EW    = 8,
    parameter int ACC_W = 18
) (
    input logic clk,
    input logic reset,
    matmul_sequencer_if.slave bus
);
    localparam int MW = DIM * DIM * EW;
    localparam int IW = $clog2(MW);
    localparam logic signed [ACC_W-1:0] ELEM_MAX = ACC_W'(2 ** (EW - 1) - 1);
    localparam logic signed [ACC_W-1:0] ELEM_MIN = -ACC_W'(2 ** (EW - 1));

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t                   state_q, state_d;
    logic [MW-1:0]            a_q, a_d, b_q, b_d, work_q, work_d, result_q, result_d;
    logic [2:0]               n_q, n_d, i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     ovf_s_q, ovf_s_d, ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
    logic [IW-1:0]            a_base, b_base, c_base;
    logic signed [EW-1:0]     a_el, b_el;
    logic signed [2*EW-1:0]   prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [2:0]               n_eff, last;

    assign n_eff    = (bus.size_in == 3'd0 || bus.size_in > 3'(DIM)) ? 3'(DIM) : bus.size_in;
    assign last     = n_q - 3'd1;
    assign a_base   = IW'((int'(i_q) * DIM + int'(k_q)) * EW);
    assign b_base   = IW'((int'(k_q) * DIM + int'(j_q)) * EW);
    assign c_base   = IW'((int'(i_q) * DIM + int'(j_q)) * EW);
    assign a_el     = a_q[a_base +: EW];
    assign b_el     = b_q[b_base +: EW];
    assign prod     = a_el * b_el;
    assign prod_ext = {{(ACC_W - 2 * EW){prod[2*EW-1]}}, prod};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        acc_d    = acc_q;
        work_d   = work_q;
        ovf_s_d  = ovf_s_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: if (bus.start) begin
                a_d     = bus.matrix_a;
                b_d     = bus.matrix_b;
                n_d     = n_eff;
                i_d     = 3'd0;
                j_d     = 3'd0;
                k_d     = 3'd0;
                acc_d   = '0;
                work_d  = '0;
                ovf_s_d = 1'b0;
                state_d = MAC;
            end
            MAC: begin
                acc_d   = acc_q + prod_ext;
                k_d     = (k_q == last) ? k_q : k_q + 3'd1;
                state_d = (k_q == last) ? WRITE : MAC;
            end
            WRITE: begin
                work_d[c_base +: EW] = acc_q[EW-1:0];
                ovf_s_d = ovf_s_q | (acc_q > ELEM_MAX) | (acc_q < ELEM_MIN);
                acc_d   = '0;
                k_d     = 3'd0;
                j_d     = (j_q != last) ? j_q + 3'd1 : 3'd0;
                i_d     = (j_q != last) ? i_q : (i_q != last) ? i_q + 3'd1 : i_q;
                state_d = (j_q == last && i_q == last) ? DONE : MAC;
                // publish the whole product at once so result_out never shows a partial matrix
                result_d = (state_d == DONE) ? work_d : result_q;
                ovf_d    = (state_d == DONE) ? ovf_s_d : ovf_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == MAC) || (state_d == WRITE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= 3'd0;
            i_q      <= 3'd0;
            j_q      <= 3'd0;
            k_q      <= 3'd0;
            acc_q    <= '0;
            work_q   <= '0;
            ovf_s_q  <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            work_q   <= work_d;
            ovf_s_q  <= ovf_s_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.result_out    = result_q;
    assign bus.overflow_flag = ovf_q;
endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Time-multiplexed controller for the coprocessor's 5x5 signed 8-bit matrix product.
- Latches two flattened operand matrices on a start pulse, then steps one shared 8x8 signed multiplier and accumulator through row/column/inner indices.
- Publishes the 200-bit result and an overflow flag on completion.
- Area-cheap alternative to the fully combinational multiply path. Uses the same operand/result packing and saturation-free truncation rules, so the two are interchangeable behind the opcode decoder.

Parameters:
- DIM, 5, maximum matrix dimension; flattened buses are DIM*DIM*8 bits.
- EW, 8, element width in bits, two's complement.
- ACC_W, 18, signed accumulator width. Must hold DIM*(2^(EW-1))^2 without wrap.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- size_in  input  3  active dimension n (1..5); 0, 6 and 7 are treated as 5.
- matrix_a  input  200  operand A; element (r,c) at bits [r*40 + c*8 +: 8].
- matrix_b  input  200  operand B; same packing.
- busy  output  1  high while an operation is in progress (MAC/WRITE).
- done  output  1  one-cycle completion pulse.
- result_out  output  200  product C; same packing; elements with r>=n or c>=n are zero.
- overflow_flag  output  1  set if any C element's true sum lies outside [-128,127].

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset (any state, including mid-operation):
  - state goes to IDLE.
  - busy=0, done=0, result_out=0, overflow_flag=0.
  - Internal indices, accumulator and working result are cleared.
- States: IDLE, MAC, WRITE, DONE.
- IDLE:
  - On the edge where start=1, latch matrix_a, matrix_b and the effective n.
  - Set i=j=k=0, acc=0, clear the working result and sticky overflow, then go to MAC.
  - result_out and overflow_flag keep their previous values until DONE.
- MAC (busy=1):
  - Each cycle: acc <= acc + sext(A[i][k]) * sext(B[k][j]), using a signed 16-bit product sign-extended to ACC_W.
  - If k==n-1, go to WRITE; otherwise k++.
- WRITE (busy=1):
  - Working C[i][j] <= acc[7:0].
  - Sticky overflow |= (acc > 127 or acc < -128).
  - acc <= 0, k <= 0.
  - If j<n-1: j++, go to MAC.
  - Else if i<n-1: j=0, i++, go to MAC.
  - Else go to DONE.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - result_out and overflow_flag are loaded with the working result and sticky overflow on the edge entering DONE, so both are valid while done=1.
  - Next state is IDLE.
- Latency:
  - busy rises the cycle after start is sampled.
  - done asserts n^3 + n^2 cycles after busy rises: 150 cycles for n=5, 12 for n=2, 2 for n=1.
  - The next start is accepted one cycle after done (IDLE).
- Boundary conditions:
  - start while busy or in DONE is ignored; no queueing.
  - Operand changes after latch have no effect.
  - Both elements -128: product +16384; must not wrap in ACC_W.
  - Results are updated atomically: result_out never shows a partial product.

Test Plan:
- n=5, A=identity, B all elements 3 -> after 150 busy cycles done=1; all 25 result bytes 0x03; overflow_flag=0.
- n=5, A all 16, B all 2 -> each sum 160; every result byte 0xA0; overflow_flag=1.
- size_in=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], other elements 0x7F -> C=[[19,22],[43,50]], all other bytes 0x00; done 12 cycles after busy rises; overflow_flag=0.
- size_in=1, A[0][0]=-128, B[0][0]=-128 -> sum 16384; C[0][0]=0x00; overflow_flag=1; done 2 cycles after busy rises. Repeat with size_in=0 and confirm it is treated as n=5.
- Start an n=5 op, pulse start with different operands at busy cycle 20 -> ignored; the result matches the first operands only.
- Assert reset at busy cycle 40 -> next cycle busy=0, done=0, result_out=0, overflow_flag=0. A following start completes correctly in 150 cycles.
